mux_rr_arbiter: RTL and testbench

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

---
 rtl/mux_rr_arbiter.sv | 148 ++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: 3-way round-robin arbiter with registered grant/select and a muxed data path.
// Define ARB_BURST_LIMIT_EN to release a grant once MAX_BURST beats have been accepted.
module mux_rr_arbiter #(
  parameter int WIDTH     = 3,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             y_ready,
  output logic [2:0]       gnt,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic             busy
);
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
  localparam logic [1:0] SEL_NONE = 2'd3;

  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
    $error("mux_rr_arbiter: MAX_BURST must be within 1..15");
  end

  state_t     state_r, state_nxt_s;
  logic [2:0] gnt_r, gnt_nxt_s;
  logic [1:0] sel_r, sel_nxt_s;
  logic [1:0] last_r, last_nxt_s;
  logic [1:0] winner_s;
  logic       own_req_s, accept_s, burst_done_s, release_s;

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    rr_next = (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // First set request searching upward from start with wrap; SEL_NONE when nobody asks.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = SEL_NONE;
    for (int k = 2; k >= 0; k--) begin
      idx = 2'((int'(start) + k) % 3);
      if (r[idx]) begin
        rr_pick = idx;
      end else begin
        rr_pick = rr_pick;
      end
    end
  endfunction

  // Request and data of the currently selected requester.
  always_comb begin
    own_req_s = 1'b0;
    y         = {WIDTH{1'b0}};
    case (sel_r)
      2'd0:    begin own_req_s = req[0]; y = a; end
      2'd1:    begin own_req_s = req[1]; y = b; end
      2'd2:    begin own_req_s = req[2]; y = c; end
      default: begin own_req_s = 1'b0;   y = {WIDTH{1'b0}}; end
    endcase
  end

  assign busy      = (state_r == GRANT);
  assign y_valid   = busy && own_req_s;
  assign accept_s  = y_valid && y_ready;
  assign release_s = busy && (!own_req_s || burst_done_s);
  assign gnt       = gnt_r;
  assign sel       = sel_r;

`ifdef ARB_BURST_LIMIT_EN
  logic [3:0] cnt_r, cnt_nxt_s;
  assign burst_done_s = accept_s && (cnt_r == 4'(MAX_BURST - 1));

  // Beat counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= 4'd0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end
`else
  logic unused_accept_s;
  assign unused_accept_s = accept_s;
  assign burst_done_s    = 1'b0;
`endif

  // Next-state: in GRANT last_r equals the granted index, so rr_next(last_r) is granted+1.
  always_comb begin
    state_nxt_s = state_r;
    gnt_nxt_s   = gnt_r;
    sel_nxt_s   = sel_r;
    last_nxt_s  = last_r;
`ifdef ARB_BURST_LIMIT_EN
    cnt_nxt_s   = cnt_r;
`endif
    winner_s    = rr_pick(req, rr_next(last_r));
    case (state_r)
      IDLE, GRANT: begin
        if (state_r == IDLE || release_s) begin
          if (winner_s != SEL_NONE) begin
            state_nxt_s = GRANT;
            gnt_nxt_s   = 3'b001 << winner_s;
            sel_nxt_s   = winner_s;
            last_nxt_s  = winner_s;
`ifdef ARB_BURST_LIMIT_EN
            cnt_nxt_s   = 4'd0;
`endif
          end else begin
            state_nxt_s = IDLE;
            gnt_nxt_s   = 3'b000;
            sel_nxt_s   = SEL_NONE;
          end
        end else begin
`ifdef ARB_BURST_LIMIT_EN
          if (accept_s) begin
            cnt_nxt_s = cnt_r + 4'd1;
          end else begin
            cnt_nxt_s = cnt_r;
          end
`endif
          state_nxt_s = GRANT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        gnt_nxt_s   = 3'b000;
        sel_nxt_s   = SEL_NONE;
      end
    endcase
  end

  // Arbiter state, grant, select and round-robin pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      gnt_r   <= 3'b000;
      sel_r   <= SEL_NONE;
      last_r  <= 2'd2;
    end else begin
      state_r <= state_nxt_s;
      gnt_r   <= gnt_nxt_s;
      sel_r   <= sel_nxt_s;
      last_r  <= last_nxt_s;
    end
  end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: a cycle-level behavioural model compared every
// falling edge, plus directed scenarios with hand-computed expectations.
module tb_mux_rr_arbiter;
  localparam int WIDTH     = 3;
  localparam int MAX_BURST = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [2:0]       req = 3'b000;
  logic [WIDTH-1:0] a = '0, b = '0, c = '0;
  logic             y_ready = 1'b0;
  logic [2:0]       gnt;
  logic [1:0]       sel;
  logic [WIDTH-1:0] y;
  logic             y_valid, busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .c(c), .y_ready(y_ready),
    .gnt(gnt), .sel(sel), .y(y), .y_valid(y_valid), .busy(busy)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who holds the grant (-1 = nobody), last winner, beats taken in this grant.
  typedef struct packed { int cur; int last; int beats; } mstate_t;
  mstate_t m;

  function automatic int pick(input logic [2:0] r, input int start);
    for (int k = 0; k < 3; k++) begin
      if (r[(start + k) % 3]) return (start + k) % 3;
    end
    return -1;
  endfunction

  function automatic mstate_t model_step(input mstate_t s, input logic [2:0] r, input logic rdy);
    mstate_t n = s;
    int      w = -1;
    bit      rel = 1'b0;
    if (s.cur < 0) begin
      w = pick(r, (s.last + 1) % 3);
    end else begin
      rel = (r[s.cur] == 1'b0);
      if (r[s.cur] && rdy) begin
        n.beats = s.beats + 1;
`ifdef ARB_BURST_LIMIT_EN
        if (n.beats >= MAX_BURST) rel = 1'b1;
`endif
      end
      if (rel) w = pick(r, (s.cur + 1) % 3);
    end
    if (s.cur < 0 || rel) begin
      n.cur = w;
      if (w >= 0) begin
        n.last  = w;
        n.beats = 0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '{cur: -1, last: 2, beats: 0};
    else     m <= model_step(m, req, y_ready);
  end

  function automatic int exp_y(input mstate_t s);
    case (s.cur)
      0:       return int'(a);
      1:       return int'(b);
      2:       return int'(c);
      default: return 0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (n_cmp > 0) begin
      check("model_gnt", int'(gnt), (m.cur < 0) ? 0 : (1 << m.cur));
      check("model_sel", int'(sel), (m.cur < 0) ? 3 : m.cur);
      check("model_y", int'(y), exp_y(m));
      check("model_y_valid", int'(y_valid), (m.cur >= 0 && req[m.cur]) ? 1 : 0);
      check("model_busy", int'(busy), (m.cur >= 0) ? 1 : 0);
    end
  end

  int exp_seq [7];
  logic [2:0] vec_req [24] = '{3'b111, 3'b111, 3'b011, 3'b011, 3'b000, 3'b101, 3'b101, 3'b100,
                               3'b001, 3'b001, 3'b111, 3'b110, 3'b110, 3'b010, 3'b000, 3'b000,
                               3'b011, 3'b111, 3'b111, 3'b101, 3'b100, 3'b100, 3'b111, 3'b001};
  logic       vec_rdy [24] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                               1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                               1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
`ifdef ARB_BURST_LIMIT_EN
    exp_seq = '{1, 1, 2, 2, 3, 3, 1};
`else
    exp_seq = '{1, 1, 1, 1, 1, 1, 1};
`endif
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_gnt", int'(gnt), 0);
    check("rst_sel", int'(sel), 3);
    check("rst_y", int'(y), 0);
    check("rst_y_valid", int'(y_valid), 0);
    check("rst_busy", int'(busy), 0);

    // No requests: stays idle.
    @(posedge clk); #1 rst = 1'b0; req = 3'b000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check("idle_busy", int'(busy), 0);
      check("idle_y_valid", int'(y_valid), 0);
      check("idle_sel", int'(sel), 3);
    end

    // All request, always ready: rotation (burst limit) or held grant.
    @(posedge clk); #1 a = 3'd1; b = 3'd2; c = 3'd3; req = 3'b111; y_ready = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); #1;
      check("burst_y", int'(y), exp_seq[i]);
    end

    // Move the grant to c, then pulse reset asynchronously mid-grant.
    @(posedge clk); #1 req = 3'b100;
    @(posedge clk);
    @(negedge clk); #1;
    check("to_c_gnt", int'(gnt), 4);
    #2 rst = 1'b1;
    #1;
    check("async_rst_gnt", int'(gnt), 0);
    check("async_rst_sel", int'(sel), 3);
    check("async_rst_y", int'(y), 0);
    req = 3'b111;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    check("first_after_rst_gnt", int'(gnt), 1);

    // Only b requests while downstream stalls.
    @(posedge clk); #1 req = 3'b010; y_ready = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("stall_gnt", int'(gnt), 2);
      check("stall_y_valid", int'(y_valid), 1);
      check("stall_y", int'(y), 2);
    end
    @(posedge clk); #1 y_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("sole_regrant_gnt", int'(gnt), 2);
    end

    // b drops while c requests: handover to c with no idle bubble.
    @(posedge clk); #1 y_ready = 1'b0; req = 3'b110;
    @(negedge clk); #1;
    check("pre_drop_gnt", int'(gnt), 2);
    @(posedge clk); #1 req = 3'b100;
    @(posedge clk);
    @(negedge clk); #1;
    check("handover_gnt", int'(gnt), 4);
    check("handover_sel", int'(sel), 2);
    check("handover_y", int'(y), 3);

    // Directed vector table, checked against the model each cycle.
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      req     = vec_req[i];
      y_ready = vec_rdy[i];
      a       = 3'(i);
      b       = 3'(i + 3);
      c       = 3'(7 - i);
    end
    @(posedge clk); #1 req = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
